// File: rtl/flb_pkg.sv
// flb_pkg: shared types and constants for the FLB lag controller.
//   flb_lag_t            - 2-bit clock lag selector
//   flb_lag_ctrl_state_e - controller state (IDLE, ARM, RUN)
//   FLB_SETTLE           - per_cnt value at which a lag change is safe
package flb_pkg;

    typedef logic [1:0] flb_lag_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } flb_lag_ctrl_state_e;

    // 4-tap synchronizer chain + dec_clk register + 1 cycle of margin
    localparam int FLB_SETTLE = 6;

endpackage

// File: rtl/flb_ref_edge_det.sv
// flb_ref_edge_det: synchronizes ref_clk into nsh_clk and flags its rising edge.
//   nsh_clk       in  system clock
//   csr_flb_rst_n in  asynchronous active-low reset
//   ref_clk       in  reference clock, asynchronous to nsh_clk
//   ref_rise      out one nsh_clk cycle high per synchronized ref_clk rise
module flb_ref_edge_det (
    input  logic nsh_clk,
    input  logic csr_flb_rst_n,
    input  logic ref_clk,
    output logic ref_rise
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], ref_clk};
        prev_d = sync_q[1];
    end

    always_ff @(posedge nsh_clk or negedge csr_flb_rst_n) begin
        if (!csr_flb_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign ref_rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/flb_lag_ctrl.sv
// flb_lag_ctrl: measures the ref_clk period, tracks lock, and applies software
// smpl/mtrx lag requests only inside the safe window of each ref period.
//   nsh_clk, csr_flb_rst_n               clock, asynchronous active-low reset
//   ref_clk                              reference clock (asynchronous)
//   csr_flb_en                           controller enable level
//   csr_smpl_lag_req, csr_mtrx_lag_req   requested lags
//   csr_lag_apply                        one-cycle capture/apply pulse
//   csr_min_period                       minimum legal ref period
//   flb_smpl_clk_lag, flb_mtrx_clk_lag   lags driven to the synchronizer
//   lag_apply_done, lag_req_err          one-cycle status pulses
//   ref_period, period_err, ref_lock     period monitor outputs
// Optional feature macro FLB_LAG_CTRL_PERIOD_MON_EN: when defined, period
// measurement, lock and period_err are built; otherwise those outputs are 0.
module flb_lag_ctrl
    import flb_pkg::*;
#(
    parameter int PER_W    = 12,
    parameter int LOCK_CNT = 4,
    parameter int PER_TOL  = 2
) (
    input  logic             nsh_clk,
    input  logic             csr_flb_rst_n,
    input  logic             ref_clk,
    input  logic             csr_flb_en,
    input  logic [1:0]       csr_smpl_lag_req,
    input  logic [1:0]       csr_mtrx_lag_req,
    input  logic             csr_lag_apply,
    input  logic [PER_W-1:0] csr_min_period,
    output logic [1:0]       flb_smpl_clk_lag,
    output logic [1:0]       flb_mtrx_clk_lag,
    output logic             lag_apply_done,
    output logic             lag_req_err,
    output logic [PER_W-1:0] ref_period,
    output logic             period_err,
    output logic             ref_lock
);

    localparam logic [PER_W-1:0] PER_MAX = '1;
    localparam logic [PER_W-1:0] SETTLE  = PER_W'(FLB_SETTLE);

    logic ref_rise;

    flb_ref_edge_det u_edge (
        .nsh_clk       (nsh_clk),
        .csr_flb_rst_n (csr_flb_rst_n),
        .ref_clk       (ref_clk),
        .ref_rise      (ref_rise)
    );

    flb_lag_ctrl_state_e state_q, state_d;
    logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
    logic                pend_q, pend_d;
    flb_lag_t            pend_smpl_q, pend_smpl_d, pend_mtrx_q, pend_mtrx_d;
    flb_lag_t            smpl_lag_q, smpl_lag_d, mtrx_lag_q, mtrx_lag_d;
    logic                done_q, done_d, err_q, err_d;
    logic                req_bad, capture, apply_now;

    always_comb begin
        state_d = state_q;
        if (!csr_flb_en)
            state_d = ST_IDLE;
        else if (state_q == ST_IDLE)
            state_d = ST_ARM;
        else if (state_q == ST_ARM && ref_rise)
            state_d = ST_RUN;
        per_cnt_d   = (state_q == ST_IDLE || ref_rise) ? '0 :
                      (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + 1'b1;
        req_bad     = csr_mtrx_lag_req < csr_smpl_lag_req;
        capture     = csr_lag_apply & ~req_bad;
        // Outside RUN there is no ref timing to protect, so apply right away
        apply_now   = pend_q & (state_q != ST_RUN || per_cnt_q == SETTLE);
        // A capture coinciding with an apply becomes the next pending request
        pend_d      = capture | (pend_q & ~apply_now);
        pend_smpl_d = capture ? csr_smpl_lag_req : pend_smpl_q;
        pend_mtrx_d = capture ? csr_mtrx_lag_req : pend_mtrx_q;
        smpl_lag_d  = apply_now ? pend_smpl_q : smpl_lag_q;
        mtrx_lag_d  = apply_now ? pend_mtrx_q : mtrx_lag_q;
        done_d      = apply_now;
        err_d       = csr_lag_apply & req_bad;
    end

    always_ff @(posedge nsh_clk or negedge csr_flb_rst_n) begin
        if (!csr_flb_rst_n) begin
            state_q     <= ST_IDLE;
            per_cnt_q   <= '0;
            pend_q      <= 1'b0;
            pend_smpl_q <= '0;
            pend_mtrx_q <= '0;
            smpl_lag_q  <= '0;
            mtrx_lag_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            pend_q      <= pend_d;
            pend_smpl_q <= pend_smpl_d;
            pend_mtrx_q <= pend_mtrx_d;
            smpl_lag_q  <= smpl_lag_d;
            mtrx_lag_q  <= mtrx_lag_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign flb_smpl_clk_lag = smpl_lag_q;
    assign flb_mtrx_clk_lag = mtrx_lag_q;
    assign lag_apply_done   = done_q;
    assign lag_req_err      = err_q;

`ifdef FLB_LAG_CTRL_PERIOD_MON_EN
    localparam int               SC_W   = $clog2(LOCK_CNT + 1);
    localparam logic [SC_W-1:0]  SC_MAX = SC_W'(LOCK_CNT);
    localparam logic [PER_W-1:0] TOL    = PER_W'(PER_TOL);

    logic [PER_W-1:0] ref_period_q, ref_period_d, new_per, per_diff;
    logic [SC_W-1:0]  stable_cnt_q, stable_cnt_d;
    logic             ref_lock_q, ref_lock_d, period_err_q, period_err_d;
    logic             is_stable;

    always_comb begin
        new_per      = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + 1'b1;
        per_diff     = (new_per > ref_period_q) ? new_per - ref_period_q : ref_period_q - new_per;
        is_stable    = (per_diff <= TOL) && (new_per >= csr_min_period);
        ref_period_d = ref_period_q;
        stable_cnt_d = stable_cnt_q;
        period_err_d = period_err_q;
        if (state_q == ST_IDLE) begin
            ref_period_d = '0;
            stable_cnt_d = '0;
            period_err_d = 1'b0;
        end else if (state_q == ST_RUN && ref_rise) begin
            ref_period_d = new_per;
            stable_cnt_d = !is_stable ? '0 :
                           (stable_cnt_q == SC_MAX) ? stable_cnt_q : stable_cnt_q + 1'b1;
            period_err_d = new_per < csr_min_period;
        end else if (state_q == ST_RUN && per_cnt_q == PER_MAX) begin
            // Counter pinned at its maximum: ref_clk has stopped
            stable_cnt_d = '0;
            period_err_d = 1'b1;
        end
        ref_lock_d = stable_cnt_d == SC_MAX;
    end

    always_ff @(posedge nsh_clk or negedge csr_flb_rst_n) begin
        if (!csr_flb_rst_n) begin
            ref_period_q <= '0;
            stable_cnt_q <= '0;
            ref_lock_q   <= 1'b0;
            period_err_q <= 1'b0;
        end else begin
            ref_period_q <= ref_period_d;
            stable_cnt_q <= stable_cnt_d;
            ref_lock_q   <= ref_lock_d;
            period_err_q <= period_err_d;
        end
    end

    assign ref_period = ref_period_q;
    assign ref_lock   = ref_lock_q;
    assign period_err = period_err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{csr_min_period, LOCK_CNT[0], PER_TOL[0]};
    assign ref_period = '0;
    assign ref_lock   = 1'b0;
    assign period_err = 1'b0;
`endif

endmodule

// File: tb/tb_flb_lag_ctrl.sv
// tb_flb_lag_ctrl: scoreboard bench for flb_lag_ctrl; apply/err pulses are
// checked by a monitor against queued expectations including exact cycle.
module tb_flb_lag_ctrl;

`ifdef FLB_LAG_CTRL_PERIOD_MON_EN
    localparam int MON = 1;
`else
    localparam int MON = 0;
`endif

    logic        nsh_clk = 1'b0;
    logic        csr_flb_rst_n = 1'b0;
    logic        ref_clk = 1'b0;
    logic        csr_flb_en = 1'b0;
    logic        csr_lag_apply = 1'b0;
    logic [1:0]  csr_smpl_lag_req = 2'd0;
    logic [1:0]  csr_mtrx_lag_req = 2'd0;
    logic [11:0] csr_min_period = 12'd8;
    logic [1:0]  flb_smpl_clk_lag, flb_mtrx_clk_lag;
    logic        lag_apply_done, lag_req_err, period_err, ref_lock;
    logic [11:0] ref_period;

    typedef struct { int s; int m; int c; } ap_t;
    ap_t ap_q[$];
    int  er_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ref_per = 0;
    int rise_n = 0;
    int rise_cyc = 0;

    flb_lag_ctrl dut (
        .nsh_clk          (nsh_clk),
        .csr_flb_rst_n    (csr_flb_rst_n),
        .ref_clk          (ref_clk),
        .csr_flb_en       (csr_flb_en),
        .csr_smpl_lag_req (csr_smpl_lag_req),
        .csr_mtrx_lag_req (csr_mtrx_lag_req),
        .csr_lag_apply    (csr_lag_apply),
        .csr_min_period   (csr_min_period),
        .flb_smpl_clk_lag (flb_smpl_clk_lag),
        .flb_mtrx_clk_lag (flb_mtrx_clk_lag),
        .lag_apply_done   (lag_apply_done),
        .lag_req_err      (lag_req_err),
        .ref_period       (ref_period),
        .period_err       (period_err),
        .ref_lock         (ref_lock)
    );

    always #5 nsh_clk = ~nsh_clk;
    always @(posedge nsh_clk) cyc <= cyc + 1;

    // ref_clk generator: period ref_per nsh cycles, edges on nsh negedges
    initial begin
        int rc;
        rc = 0;
        forever begin
            @(negedge nsh_clk);
            if (ref_per != 0) begin
                rc++;
                if (rc >= ref_per) begin
                    rc = 0;
                    ref_clk = 1'b1;
                    rise_cyc = cyc;
                    rise_n++;
                end else if (rc == ref_per / 2) begin
                    ref_clk = 1'b0;
                end
            end else begin
                rc = 0;
                ref_clk = 1'b0;
            end
        end
    end

    // monitor: every done/err pulse must match the head of its queue
    initial begin
        ap_t e;
        int  ec;
        forever begin
            @(negedge nsh_clk);
            if (lag_apply_done) begin
                total++;
                if (ap_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = ap_q.pop_front();
                    if (flb_smpl_clk_lag != e.s[1:0] || flb_mtrx_clk_lag != e.m[1:0] || cyc != e.c) begin
                        bad++;
                        $display("FAIL done_check: got smpl=%0d mtrx=%0d cycle=%0d, expected smpl=%0d mtrx=%0d cycle=%0d",
                                 flb_smpl_clk_lag, flb_mtrx_clk_lag, cyc, e.s, e.m, e.c);
                    end
                end
            end
            if (lag_req_err) begin
                total++;
                if (er_q.size() == 0) begin
                    bad++;
                    $display("FAIL err_unexpected: got lag_req_err at cycle %0d, expected none", cyc);
                end else begin
                    ec = er_q.pop_front();
                    if (cyc != ec) begin
                        bad++;
                        $display("FAIL err_check: got lag_req_err at cycle %0d, expected cycle %0d", cyc, ec);
                    end
                end
            end
        end
    end

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", n, a, e);
        end
    endtask

    task automatic pulse(input int s, input int m);
        csr_smpl_lag_req = s[1:0];
        csr_mtrx_lag_req = m[1:0];
        csr_lag_apply = 1'b1;
        @(negedge nsh_clk);
        csr_lag_apply = 1'b0;
    endtask

    task automatic wait_rise();
        int n;
        int t;
        n = rise_n;
        t = 0;
        while (rise_n == n && t < 200) begin
            @(negedge nsh_clk);
            t++;
        end
        if (rise_n == n) begin
            total++;
            bad++;
            $display("FAIL rise_timeout: got no ref rise in 200 cycles, expected one");
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge nsh_clk);
    endtask

    task automatic drain(input string n);
        int t;
        t = 0;
        while ((ap_q.size() != 0 || er_q.size() != 0) && t < 100) begin
            @(negedge nsh_clk);
            t++;
        end
        chk(n, ap_q.size() + er_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge nsh_clk);
        chk("rst_smpl", flb_smpl_clk_lag, 0);
        chk("rst_mtrx", flb_mtrx_clk_lag, 0);
        chk("rst_done", lag_apply_done, 0);
        chk("rst_err", lag_req_err, 0);
        chk("rst_period", ref_period, 0);
        chk("rst_perr", period_err, 0);
        chk("rst_lock", ref_lock, 0);
        csr_flb_rst_n = 1'b1;
        @(negedge nsh_clk);

        // IDLE: apply lands the cycle after capture
        ap_q.push_back('{1, 2, cyc + 2});
        pulse(1, 2);
        drain("idle_apply");
        chk("idle_smpl", flb_smpl_clk_lag, 1);
        chk("idle_mtrx", flb_mtrx_clk_lag, 2);

        // period 20: rise 1 arms, rise 2 is the first measurement
        csr_flb_en = 1'b1;
        ref_per = 20;
        wait_rise();
        wait_rise();
        wait_to(rise_cyc + 4);
        chk("first_period", ref_period, MON * 20);
        chk("first_lock", ref_lock, 0);
        chk("first_perr", period_err, 0);
        repeat (3) wait_rise();
        wait_to(rise_cyc + 4);
        chk("lock_3_stable", ref_lock, 0);
        wait_rise();
        wait_to(rise_cyc + 4);
        chk("lock_4_stable", ref_lock, MON);

        // mid-period request lands 7 cycles after the next ref_rise
        wait_to(rise_cyc + 10);
        ap_q.push_back('{1, 3, rise_cyc + 30});
        pulse(1, 3);
        drain("window_apply");

        // mtrx < smpl is rejected, lags untouched
        er_q.push_back(cyc + 1);
        pulse(3, 1);
        drain("bad_req");
        repeat (30) @(negedge nsh_clk);
        chk("bad_smpl", flb_smpl_clk_lag, 1);
        chk("bad_mtrx", flb_mtrx_clk_lag, 3);

        // two requests before the window: last one wins, single done
        wait_rise();
        wait_to(rise_cyc + 12);
        ap_q.push_back('{2, 3, rise_cyc + 30});
        pulse(1, 2);
        pulse(2, 3);
        drain("overwrite_apply");
        chk("lock_held", ref_lock, MON);

        // period jump 20 -> 30 drops lock on that rise
        wait_rise();
        wait_to(rise_cyc + 4);
        ref_per = 30;
        wait_rise();
        wait_to(rise_cyc + 4);
        chk("jump_period", ref_period, MON * 30);
        chk("jump_lock", ref_lock, 0);

        // ref stopped: error only once per_cnt saturates
        ref_per = 0;
        wait_to(rise_cyc + 4090);
        chk("lost_early_perr", period_err, 0);
        wait_to(rise_cyc + 4110);
        chk("lost_perr", period_err, MON);
        chk("lost_lock", ref_lock, 0);

        // restart at 20 clears the error
        ref_per = 20;
        wait_rise();
        wait_rise();
        wait_to(rise_cyc + 4);
        chk("restart_period", ref_period, MON * 20);
        chk("restart_perr", period_err, 0);

        // period below minimum
        csr_min_period = 12'd25;
        wait_rise();
        wait_to(rise_cyc + 4);
        chk("min_perr", period_err, MON);
        chk("min_lock", ref_lock, 0);
        csr_min_period = 12'd8;
        wait_rise();
        wait_to(rise_cyc + 4);
        chk("min_clear_perr", period_err, 0);

        // reset while a request is pending discards it
        wait_rise();
        wait_to(rise_cyc + 12);
        pulse(1, 1);
        @(negedge nsh_clk);
        csr_flb_rst_n = 1'b0;
        #1;
        chk("rstp_smpl", flb_smpl_clk_lag, 0);
        chk("rstp_mtrx", flb_mtrx_clk_lag, 0);
        chk("rstp_period", ref_period, 0);
        repeat (2) @(negedge nsh_clk);
        csr_flb_rst_n = 1'b1;
        repeat (60) @(negedge nsh_clk);
        chk("rstp_smpl_after", flb_smpl_clk_lag, 0);
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
